bht_branch_predictor: RTL
=========================

Name: bht_branch_predictor

Overview:
- Dynamic next-PC predictor for the IF stage of the mini CPU.
- Replaces static "backward-taken" prediction with a direct-mapped table of 2-bit saturating counters, indexed by PC.
- The table is trained by branch resolutions from EX.
- JAL is always predicted taken. JALR is not predicted and falls through to pc+4.
- Also keeps a saturating mispredict counter for performance inspection.

Parameters:
- XLEN, 32, width of PC, instruction and immediates.
- BHT_DEPTH, 64, number of counter entries; power of 2, minimum 2.
- CNT_INIT, 2'b01, counter value loaded on reset (weakly not-taken).
- PERF_W, 16, width of the mispredict counter.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high reset.
- if_pc, in, XLEN, PC of the fetched instruction.
- if_instr, in, 32, fetched instruction.
- pre_pc, out, XLEN, predicted next PC.
- pre_taken, out, 1, 1 when pre_pc is a branch/jump target.
- upd_valid, in, 1, EX reports a resolved conditional branch this cycle.
- upd_pc, in, XLEN, PC of the resolved branch.
- upd_taken, in, 1, actual branch outcome.
- upd_mispredict, in, 1, EX detected a wrong prediction; only sampled when upd_valid=1.
- perf_mispred, out, PERF_W, saturating count of mispredictions.

Behaviour:
- IDX_W = log2(BHT_DEPTH).
- Entry index = pc[IDX_W+1:2]; pc[1:0] is ignored and there are no tags, so aliasing is accepted.
- Decode:
  - is_bxx = if_instr[6:0]==7'b1100011.
  - is_jal = if_instr[6:0]==7'b1101111.
- Immediates:
  - bimm = sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
  - jimm = sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
- Prediction path is purely combinational from the registered table; zero-cycle latency.
  - is_jal: pre_taken=1, pre_pc=if_pc+jimm.
  - is_bxx and cnt[idx][1]==1: pre_taken=1, pre_pc=if_pc+bimm.
  - Otherwise: pre_taken=0, pre_pc=if_pc+4.
  - All additions are modulo 2^XLEN; wrap-around is silent.
- Update path is sequential, one-cycle write latency. On a rising edge with upd_valid=1 and reset=0:
  - upd_taken=1: counter increments, saturating at 2'b11.
  - upd_taken=0: counter decrements, saturating at 2'b00.
  - Only the one indexed entry changes.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff bit[1]=1.
- Read/write same index in the same cycle: the prediction uses the pre-update value unless BHT_BYPASS_EN is defined.
- perf_mispred:
  - Increments by 1 on an edge with upd_valid=1 and upd_mispredict=1.
  - Holds at all-ones (2^PERF_W-1) once reached.
  - upd_mispredict with upd_valid=0 is ignored.
- Reset, including reset asserted mid-operation:
  - Every entry is loaded with CNT_INIT in the same edge.
  - perf_mispred goes to 0.
  - A concurrent upd_valid is dropped.
  - Outputs pre_pc/pre_taken are combinational, so after reset they reflect CNT_INIT (default: branches predicted not-taken, pre_pc=if_pc+4).
- No stall input: IF holds if_pc/if_instr steady when stalled, and the output follows.

Optional Feature:
- Macro: BHT_BYPASS_EN.
- Defined: if upd_valid=1 and the update index equals the if_pc index in the same cycle, the prediction uses the counter value being written this edge (post-saturation next value), combinationally forwarded.
- Not defined: the prediction uses the stored pre-update value, with no forwarding logic.
- Training and counter behaviour are otherwise identical in both builds.

Test Plan:
- Reset, then if_pc=0x100, if_instr=0xFE000EE3 (beq, bimm=-4) -> pre_taken=0, pre_pc=0x104; perf_mispred=0.
- Two updates upd_pc=0x100, upd_taken=1, then same fetch -> pre_taken=1, pre_pc=0x0FC. Three further taken updates -> counter stays 11. One not-taken update -> still taken (10). A second not-taken update -> pre_pc=0x104.
- if_pc=0x200, if_instr=0x0080006F (jal +8) -> pre_taken=1, pre_pc=0x208 regardless of table state. if_instr=0x00000013 (addi) -> pre_pc=0x204.
- Aliasing with BHT_DEPTH=64: train upd_pc=0x100 to taken twice -> fetch at 0x200 (same index) with a beq also predicts taken.
- Same-cycle update: counter at 01, upd_valid=1, upd_taken=1, upd_pc=if_pc=0x100, beq fetch -> pre_taken=0 without BHT_BYPASS_EN, pre_taken=1 with it.
- perf counter: PERF_W=4, 20 cycles of upd_valid=1 and upd_mispredict=1 -> perf_mispred=15 and holds. Assert reset mid-sequence with upd_valid=1 -> perf_mispred=0 and entry at CNT_INIT.

Source files
------------

// File: rtl/bht_branch_predictor.sv
// Next-PC predictor for IF: direct-mapped 2-bit counter table trained from EX, JAL always taken.
// Optional macro BHT_BYPASS_EN forwards a same-cycle counter update into the prediction.
module bht_branch_predictor #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         PERF_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [31:0]       if_instr,
  output logic [XLEN-1:0]   pre_pc,
  output logic              pre_taken,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic [PERF_W-1:0] perf_mispred
);
  localparam int              IDX_W    = $clog2(BHT_DEPTH);
  localparam logic [6:0]      OP_BXX   = 7'b1100011;
  localparam logic [6:0]      OP_JAL   = 7'b1101111;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  function automatic logic [1:0] cnt_train(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_ONE;
  endfunction

  logic [1:0]             cnt [BHT_DEPTH];
  logic [IDX_W-1:0]       fetch_idx;
  logic [IDX_W-1:0]       upd_idx;
  logic [1:0]             upd_cnt_nxt;
  logic [1:0]             rd_cnt;
  logic                   is_bxx;
  logic                   is_jal;
  logic signed [XLEN-1:0] bimm;
  logic signed [XLEN-1:0] jimm;
  logic                   unused_upd_pc_bits;

  assign fetch_idx   = if_pc[IDX_W+1:2];
  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign upd_cnt_nxt = cnt_train(cnt[upd_idx], upd_taken);
  // Only the index bits of the update PC matter; there are no tags.
  assign unused_upd_pc_bits = ^{upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

`ifdef BHT_BYPASS_EN
  assign rd_cnt = (upd_valid && !reset && (upd_idx == fetch_idx)) ? upd_cnt_nxt : cnt[fetch_idx];
`else
  assign rd_cnt = cnt[fetch_idx];
`endif

  assign is_bxx = (if_instr[6:0] == OP_BXX);
  assign is_jal = (if_instr[6:0] == OP_JAL);
  assign bimm   = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                   if_instr[30:25], if_instr[11:8], 1'b0};
  assign jimm   = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                   if_instr[20], if_instr[30:21], 1'b0};

  // Prediction: combinational from the stored table
  always_comb begin
    pre_taken = 1'b0;
    pre_pc    = if_pc + PC_STEP;
    if (is_jal) begin
      pre_taken = 1'b1;
      pre_pc    = if_pc + $unsigned(jimm);
    end else if (is_bxx && rd_cnt[1]) begin
      pre_taken = 1'b1;
      pre_pc    = if_pc + $unsigned(bimm);
    end
  end

  // Training and performance counting: registered on the rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) cnt[i] <= CNT_INIT;
      perf_mispred <= '0;
    end else if (upd_valid) begin
      cnt[upd_idx] <= upd_cnt_nxt;
      if (upd_mispredict) perf_mispred <= perf_sat_inc(perf_mispred);
    end
  end
endmodule
